delayw_prog: RTL

- Parametrised successor to the fixed 8-bit delay stage.
- Delays a sample stream by a run-time programmable number of sample strobes, from 0 to MAX_DELAY.
- Uses a circular buffer with a history counter, so the delay can change on the fly without flushing valid history.
- Sits in the DSP filter chain ahead of tap/adder stages that need aligned, gated samples.

---
 rtl/delayw_prog.sv | 92 +++++++++
 1 files changed

// File: rtl/delayw_prog.sv
// Programmable sample delay line built on a circular buffer.
// A history counter gates o_valid, so the delay can change without a flush.
module delayw_prog #(
   parameter int DW        = 8,
   parameter int MAX_DELAY = 16,
   parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_ce,
   input  logic             i_flush,
   input  logic [DW-1:0]    i_data,
   input  logic [DLY_W-1:0] i_delay,
   output logic [DW-1:0]    o_data,
   output logic             o_valid,
   output logic             o_delay_err
);

   localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   localparam logic [DLY_W-1:0] L_MAXD = DLY_W'(MAX_DELAY);
   localparam logic [DLY_W:0]   L_MAXX = (DLY_W+1)'(MAX_DELAY);
   localparam logic [PW-1:0]    L_LAST = PW'(MAX_DELAY - 1);

   typedef enum logic {S_FILL, S_FULL} state_t;

   logic [DW-1:0]    r_buf [MAX_DELAY];
   logic [PW-1:0]    r_wr_ptr;
   logic [DLY_W-1:0] r_hist;
   state_t           r_state;

   logic             w_err;
   logic [DLY_W-1:0] w_deff;
   logic             w_ok;
   logic [DLY_W:0]   w_ptr_x;
   logic [DLY_W:0]   w_deff_x;
   logic [DLY_W:0]   w_rd_x;
   logic [PW-1:0]    w_rd_idx;
   logic [DW-1:0]    w_rd_data;
   logic [PW-1:0]    w_ptr_nxt;
   logic [DLY_W-1:0] w_hist_nxt;

   assign w_err    = (i_delay > L_MAXD);
   assign w_deff   = w_err ? L_MAXD : i_delay;
   // FULL already guarantees hist == MAX_DELAY >= any clamped delay
   assign w_ok     = (r_state == S_FULL) || (r_hist >= w_deff);

   // Modular read index without relying on power-of-2 truncation
   assign w_ptr_x  = (DLY_W+1)'(r_wr_ptr);
   assign w_deff_x = {1'b0, w_deff};
   assign w_rd_x   = (w_ptr_x >= w_deff_x) ? (w_ptr_x - w_deff_x)
                                           : (w_ptr_x + L_MAXX - w_deff_x);
   assign w_rd_idx  = PW'(w_rd_x);
   assign w_rd_data = (w_deff == '0) ? i_data : r_buf[w_rd_idx];

   assign w_ptr_nxt  = (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
   assign w_hist_nxt = (r_hist == L_MAXD) ? r_hist : r_hist + 1'b1;

   // Storage is deliberately not reset; hist keeps stale entries unread
   always_ff @(posedge i_clk) begin
      if (i_ce && !i_flush)
         r_buf[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_delay_err <= 1'b0;
         r_wr_ptr    <= '0;
         r_hist      <= '0;
         r_state     <= S_FILL;
      end else if (i_flush) begin
         o_valid     <= 1'b0;
         o_delay_err <= 1'b0;
         r_wr_ptr    <= '0;
         r_hist      <= '0;
         r_state     <= S_FILL;
      end else if (i_ce) begin
         o_valid     <= w_ok;
         o_delay_err <= w_err;
         o_data      <= w_ok ? w_rd_data : '0;
         r_wr_ptr    <= w_ptr_nxt;
         r_hist      <= w_hist_nxt;
         if (w_hist_nxt == L_MAXD)
            r_state <= S_FULL;
      end else begin
         o_valid     <= 1'b0;
         o_delay_err <= 1'b0;
      end
   end

endmodule
